// File: rtl/seq_arbiter_pkg.sv
// Shared types and reset constants for the round-robin sequence arbiter.
// The state encoding is fixed: IDLE=00, RUN=01, DONE=10, and 11 is illegal.
package seq_arbiter_pkg;

    localparam int ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam state_t RST_STATE = IDLE;
    localparam logic   RST_BIT   = 1'b0;

endpackage

// File: rtl/seq_arbiter_rr_pick.sv
// Combinational rotate-priority find-first.
// The search starts at ptr+1 (mod N) and wraps around.
module rr_pick #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    win,
    output logic [ID_W-1:0] win_id,
    output logic            any
);

    logic found_s;
    logic hit_s;

    function automatic logic [ID_W-1:0] rot_idx(input logic [ID_W-1:0] p, input int i);
        int t;
        t = (int'(p) + 1 + i) % N;
        return ID_W'(t);
    endfunction

    // Walk requesters in rotated order; the first hit claims the grant.
    always_comb begin
        win     = '0;
        win_id  = '0;
        found_s = 1'b0;
        hit_s   = 1'b0;
        for (int i = 0; i < N; i++) begin
            hit_s                  = req[rot_idx(ptr, i)] & ~found_s;
            win[rot_idx(ptr, i)]   = hit_s;
            win_id                 = hit_s ? rot_idx(ptr, i) : win_id;
            found_s                = found_s | hit_s;
        end
    end

    assign any = |req;

endmodule

// File: rtl/seq_arbiter.sv
// Round-robin arbiter that hands a fixed-length strobe sequence to one requester at a time.
// The FSM, run counter, rotation pointer and all registered outputs live here.
module seq_arbiter
    import seq_arbiter_pkg::*;
#(
    parameter int N   = 4,
    parameter int LEN = 3
) (
    input  logic                 CLK,
    input  logic                 R,
    input  logic [N-1:0]         req,
    input  logic                 abort,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] gid,
    output logic                 busy,
    output logic                 s,
    output logic                 done
);

    localparam int                ID_W     = $clog2(N);
    localparam int                CNT_W    = $clog2(LEN);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(LEN - 1);
    localparam logic [ID_W-1:0]   PTR_RST  = ID_W'(N - 1);

    state_t            state_r, state_nx;
    logic [CNT_W-1:0]  cnt_r, cnt_nx;
    logic [ID_W-1:0]   ptr_r, ptr_nx;
    logic [N-1:0]      grant_r, grant_nx;
    logic [ID_W-1:0]   gid_r, gid_nx;
    logic              busy_r, busy_nx;
    logic              s_r, s_nx;
    logic              done_r, done_nx;

    logic [N-1:0]      win_s;
    logic [ID_W-1:0]   win_id_s;
    logic              any_s;

    rr_pick #(
        .N    (N),
        .ID_W (ID_W)
    ) u_pick (
        .req    (req),
        .ptr    (ptr_r),
        .win    (win_s),
        .win_id (win_id_s),
        .any    (any_s)
    );

    // Next-state and next-output decode; outputs come from the post-edge state so they register cleanly.
    always_comb begin
        state_nx = state_r;
        cnt_nx   = cnt_r;
        ptr_nx   = ptr_r;
        grant_nx = grant_r;
        gid_nx   = gid_r;
        case (state_r)
            IDLE: begin
                if (any_s) begin
                    state_nx = RUN;
                    grant_nx = win_s;
                    gid_nx   = win_id_s;
                    cnt_nx   = '0;
                end else begin
                    grant_nx = '0;
                end
            end
            RUN: begin
                if (abort || (cnt_r == CNT_LAST)) begin
                    state_nx = DONE;
                    grant_nx = '0;
                end else begin
                    cnt_nx = cnt_r + CNT_W'(1'b1);
                end
            end
            DONE: begin
                state_nx = IDLE;
                ptr_nx   = gid_r;
                grant_nx = '0;
            end
            default: begin
                state_nx = IDLE;
                grant_nx = '0;
                cnt_nx   = '0;
            end
        endcase
        busy_nx = (state_nx == RUN);
        done_nx = (state_nx == DONE);
        s_nx    = (state_nx == RUN) ? cnt_nx[0] : 1'b0;
    end

    // State, counter, pointer and output registers.
    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            state_r <= RST_STATE;
            cnt_r   <= '0;
            ptr_r   <= PTR_RST;
            grant_r <= '0;
            gid_r   <= '0;
            busy_r  <= RST_BIT;
            s_r     <= RST_BIT;
            done_r  <= RST_BIT;
        end else begin
            state_r <= state_nx;
            cnt_r   <= cnt_nx;
            ptr_r   <= ptr_nx;
            grant_r <= grant_nx;
            gid_r   <= gid_nx;
            busy_r  <= busy_nx;
            s_r     <= s_nx;
            done_r  <= done_nx;
        end
    end

    assign grant = grant_r;
    assign gid   = gid_r;
    assign busy  = busy_r;
    assign s     = s_r;
    assign done  = done_r;

endmodule

// File: tb/tb_seq_arbiter.sv
// Self-checking bench for seq_arbiter (N=4, LEN=3): run-level reference model
// compared every cycle, plus hand-computed expectations for the directed scenarios.
module tb_seq_arbiter;

    localparam int N    = 4;
    localparam int LEN  = 3;
    localparam int ID_W = 2;

    logic            CLK   = 1'b0;
    logic            R     = 1'b0;
    logic            abort = 1'b0;
    logic [N-1:0]    req   = 4'b0000;
    logic [N-1:0]    grant;
    logic [ID_W-1:0] gid;
    logic            busy;
    logic            s;
    logic            done;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: who owns the sequence, how far into its run, and who owned it last.
    int m_owner = -1;
    int m_idx   = 0;
    int m_last  = N - 1;
    int m_gid   = 0;
    bit m_done  = 1'b0;

    logic [N-1:0] cont_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    seq_arbiter #(.N(N), .LEN(LEN)) dut (
        .CLK   (CLK),
        .R     (R),
        .req   (req),
        .abort (abort),
        .grant (grant),
        .gid   (gid),
        .busy  (busy),
        .s     (s),
        .done  (done)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: actual %0h required %0h", name, $time, act, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            if (((r >> ((last + k) % N)) & 4'b0001) != 4'b0000) return (last + k) % N;
        end
        return -1;
    endfunction

    // Advance the reference model one clock, or clear it on reset.
    always @(posedge CLK or negedge R) begin : mdl
        int o, ix, la, g, w;
        bit d;
        o = m_owner; ix = m_idx; la = m_last; g = m_gid; d = m_done;
        if (!R) begin
            o = -1; ix = 0; la = N - 1; g = 0; d = 1'b0;
        end else if (d) begin
            d  = 1'b0;
            la = g;
        end else if (o >= 0) begin
            if (abort || ix == LEN - 1) begin
                o = -1;
                d = 1'b1;
            end else begin
                ix = ix + 1;
            end
        end else begin
            w = pick(req, la);
            if (w >= 0) begin
                o = w; g = w; ix = 0;
            end
        end
        m_owner <= o; m_idx <= ix; m_last <= la; m_gid <= g; m_done <= d;
    end

    // Compare every output against the model on each falling edge.
    always @(negedge CLK) begin
        check("grant", {28'd0, grant}, (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
        check("gid",   {30'd0, gid},   m_gid);
        check("busy",  {31'd0, busy},  (m_owner >= 0) ? 32'd1 : 32'd0);
        check("s",     {31'd0, s},     (m_owner >= 0 && (m_idx % 2) == 1) ? 32'd1 : 32'd0);
        check("done",  {31'd0, done},  {31'd0, m_done});
    end

    initial begin
        // Reset, then ten idle cycles with no requests.
        repeat (3) @(negedge CLK);
        R = 1'b1;
        repeat (10) @(negedge CLK);
        check("rst_grant", {28'd0, grant}, 32'h0);
        check("rst_gid",   {30'd0, gid},   32'h0);
        check("rst_flags", {29'd0, busy, s, done}, 32'h0);

        // Single request from requester 2.
        req = 4'b0100;
        @(negedge CLK);
        req = 4'b0000;
        check("single_c1_grant", {28'd0, grant}, 32'h4);
        check("single_c1_gid",   {30'd0, gid},   32'h2);
        check("single_c1_s",     {31'd0, s},     32'h0);
        @(negedge CLK);
        check("single_c2_s",     {31'd0, s},     32'h1);
        @(negedge CLK);
        check("single_c3_s",     {31'd0, s},     32'h0);
        check("single_c3_grant", {28'd0, grant}, 32'h4);
        @(negedge CLK);
        check("single_c4_done",  {31'd0, done},  32'h1);
        check("single_c4_grant", {28'd0, grant}, 32'h0);
        repeat (3) @(negedge CLK);

        // Fresh reset, then full contention.
        R = 1'b0;
        @(negedge CLK);
        R = 1'b1;
        @(negedge CLK);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            check("cont_grant", {28'd0, grant}, {28'd0, cont_exp[k]});
            repeat (3) @(negedge CLK);
            check("cont_done",  {31'd0, done},  32'h1);
            @(negedge CLK);
        end
        req = 4'b0000;
        repeat (2) @(negedge CLK);

        // Abort in the second run cycle.
        req = 4'b0010;
        @(negedge CLK);
        check("abort_c1_grant", {28'd0, grant}, 32'h2);
        @(negedge CLK);
        abort = 1'b1;
        @(negedge CLK);
        abort = 1'b0;
        check("abort_c3_done",  {31'd0, done},  32'h1);
        check("abort_c3_s",     {31'd0, s},     32'h0);
        check("abort_c3_grant", {28'd0, grant}, 32'h0);
        req = 4'b1111;
        @(negedge CLK);
        @(negedge CLK);
        check("abort_c5_grant", {28'd0, grant}, 32'h4);
        req = 4'b0000;
        repeat (5) @(negedge CLK);

        // Asynchronous reset in the middle of a run.
        req = 4'b1111;
        @(negedge CLK);
        check("areset_c1_grant", {28'd0, grant}, 32'h8);
        @(negedge CLK);
        check("areset_c2_s", {31'd0, s}, 32'h1);
        #2 R = 1'b0;
        #1;
        check("areset_grant", {28'd0, grant}, 32'h0);
        check("areset_flags", {29'd0, busy, s, done}, 32'h0);
        @(negedge CLK);
        R = 1'b1;
        @(negedge CLK);
        check("areset_regrant", {28'd0, grant}, 32'h1);
        req = 4'b0000;
        repeat (5) @(negedge CLK);

        // Owner drops its request mid-run.
        req = 4'b1000;
        @(negedge CLK);
        check("drop_c1_grant", {28'd0, grant}, 32'h8);
        @(negedge CLK);
        req = 4'b0000;
        @(negedge CLK);
        check("drop_c3_grant", {28'd0, grant}, 32'h8);
        check("drop_c3_busy",  {31'd0, busy},  32'h1);
        @(negedge CLK);
        check("drop_c4_done",  {31'd0, done},  32'h1);
        check("drop_c4_grant", {28'd0, grant}, 32'h0);
        repeat (3) @(negedge CLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
